// File: rtl/seq_divider_32by16.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_32by16
// Description : Iterative restoring divider. A 2*WIDTH-bit dividend is divided
//               by a WIDTH-bit divisor. One quotient bit is resolved per clock,
//               and a start/done handshake controls the operation.
//               Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement
//               operands (truncating division; the remainder takes the sign of
//               the dividend). This option adds a SIGN_FIX state after DIVIDE.
// Ports       : clk          rising-edge clock
//               rst_n        asynchronous active-low reset
//               start        request, sampled only in IDLE
//               dividend     [2*WIDTH-1:0] captured on the accepted start
//               divisor      [WIDTH-1:0]   captured on the accepted start
//               busy         operation in flight
//               done         one-cycle pulse, results valid from this cycle on
//               quotient     [WIDTH-1:0] result
//               remainder    [WIDTH-1:0] result
//               div_by_zero  last operation had a zero divisor
//               overflow     last quotient did not fit in WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_32by16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DIVIDE   = 2'd1;
  localparam logic [1:0] S_FINISH   = 2'd2;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [1:0] S_SIGN_FIX = 2'd3;
  localparam logic [1:0] c_after_divide = S_SIGN_FIX;
  // Largest magnitudes representable for a positive / negative quotient
  localparam logic [WIDTH-1:0] c_pos_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_neg_max = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam logic [1:0] c_after_divide = S_FINISH;
`endif
  localparam logic [CW-1:0] c_count_init = CW'(WIDTH);

  logic [1:0]        r_state;
  logic [WIDTH:0]    r_rem;        // partial remainder, one spare bit
  logic [WIDTH-1:0]  r_quo;        // quotient shift register
  logic [WIDTH-1:0]  r_divisor;
  logic [CW-1:0]     r_count;
  logic              r_dbz;
  logic              r_ovf;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  r_quotient;
  logic [WIDTH-1:0]  r_remainder;
  logic              r_dbz_out;
  logic              r_ovf_out;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic              r_sign_q;
  logic              r_sign_r;
`endif

  logic [2*WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH+1:0]   w_trial;
  logic               w_trial_neg;

`ifdef SEQ_DIVIDER_SIGNED_EN
  // The core always divides magnitudes; signs are re-applied in SIGN_FIX.
  assign w_dvd_mag = dividend[2*WIDTH-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[WIDTH-1]    ? -divisor  : divisor;
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
`endif

  // {rem,quo} shifted left by one. The partial remainder stays below the
  // divisor, so the shifted value is below 2^(WIDTH+1) and the extra top bit
  // of the subtraction is a reliable borrow.
  assign w_shift     = {r_rem, r_quo[WIDTH-1]};
  assign w_trial     = w_shift - {2'b00, r_divisor};
  assign w_trial_neg = w_trial[WIDTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz_out   <= 1'b0;
      r_ovf_out   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem     <= {1'b0, w_dvd_mag[2*WIDTH-1:WIDTH]};
            r_quo     <= w_dvd_mag[WIDTH-1:0];
            r_divisor <= w_dvs_mag;
            r_count   <= c_count_init;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_sign_q  <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r  <= dividend[2*WIDTH-1];
`endif
            if (w_dvs_mag == '0) begin
              r_dbz   <= 1'b1;
              r_state <= S_FINISH;
            end else if (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dvs_mag) begin
              // High half not below the divisor: quotient needs > WIDTH bits
              r_ovf   <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_state <= S_DIVIDE;
            end
          end
        end

        S_DIVIDE: begin
          r_rem   <= w_trial_neg ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
          r_quo   <= {r_quo[WIDTH-2:0], ~w_trial_neg};
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state <= c_after_divide;
          end
        end

`ifdef SEQ_DIVIDER_SIGNED_EN
        S_SIGN_FIX: begin
          if (r_sign_q) begin
            if (r_quo > c_neg_max) r_ovf <= 1'b1;
            r_quo <= -r_quo;
          end else if (r_quo > c_pos_max) begin
            r_ovf <= 1'b1;
          end
          if (r_sign_r) begin
            r_rem <= {1'b0, -r_rem[WIDTH-1:0]};
          end
          r_state <= S_FINISH;
        end
`endif

        S_FINISH: begin
          if (r_dbz || r_ovf) begin
            r_quotient  <= '1;
            r_remainder <= '0;
          end else begin
            r_quotient  <= r_quo;
            r_remainder <= r_rem[WIDTH-1:0];
          end
          r_dbz_out <= r_dbz;
          r_ovf_out <= r_ovf;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz_out;
  assign overflow    = r_ovf_out;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_32by16.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider_32by16
// Description : Directed self-checking bench for seq_divider_32by16.
//               Honours SEQ_DIVIDER_SIGNED_EN for the signed-mode vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider_32by16;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_compared;
  int n_mismatched;

  seq_divider_32by16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one start and waits (bounded) for done. lat counts edges from the
  // accepting edge to the edge that raised done; -1 means no done seen.
  // Returns positioned in the done cycle.
  task automatic do_op(input logic [31:0] dvd, input logic [15:0] dvs,
                       output int lat, output logic busy_ok,
                       output logic [33:0] res);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 16'h0000;
    lat      = -1;
    busy_ok  = 1'b1;
    res      = '0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (done === 1'b1) begin
        lat = i;
        res = {div_by_zero, overflow, quotient, remainder};
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        tick();
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #23;
    n_compared++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 36'd0) begin
      n_mismatched++;
      $display("FAIL reset_state: got %h want 0",
               {busy, done, quotient, remainder, div_by_zero, overflow});
    end
    rst_n = 1'b1;
    tick(); tick();
    n_compared++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 36'd0) begin
      n_mismatched++;
      $display("FAIL idle_after_reset: got %h want 0",
               {busy, done, quotient, remainder, div_by_zero, overflow});
    end
  endtask

  task automatic test_basic;
    int lat; logic bok; logic [33:0] res;
    do_op(32'd1000, 16'd7, lat, bok, res);
    n_compared++;
    if (lat !== LAT) begin n_mismatched++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    n_compared++;
    if (bok !== 1'b1) begin n_mismatched++; $display("FAIL basic_busy: busy dropped before done"); end
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    n_compared++;
    if (res !== {2'b00, 16'd142, 16'd6}) begin
      n_mismatched++; $display("FAIL basic_result: got %h want %h", res, {2'b00, 16'd142, 16'd6});
    end
    tick(); tick(); tick();
    n_compared++;
    if ({done, quotient, remainder, div_by_zero, overflow} !== {1'b0, 2'b00 == 2'b00 ? 16'd142 : 16'd0, 16'd6, 2'b00}) begin
      n_mismatched++; $display("FAIL basic_hold: got %h", {done, quotient, remainder, div_by_zero, overflow});
    end
  endtask

`ifndef SEQ_DIVIDER_SIGNED_EN
  task automatic test_max_operands;
    int lat; logic bok; logic [33:0] res;
    do_op(32'hFFFE_0001, 16'hFFFF, lat, bok, res);
    tick();
    n_compared++;
    if (lat !== LAT) begin n_mismatched++; $display("FAIL max_latency: got %0d want %0d", lat, LAT); end
    n_compared++;
    if (res !== {2'b00, 16'hFFFF, 16'h0000}) begin
      n_mismatched++; $display("FAIL max_result: got %h want %h", res, {2'b00, 16'hFFFF, 16'h0000});
    end
  endtask
`endif

  task automatic test_misc_divide;
    int lat; logic bok; logic [33:0] res;
    do_op(32'd65535, 16'd256, lat, bok, res);
    tick();
    n_compared++;
    if (res !== {2'b00, 16'd255, 16'd255} || lat !== LAT) begin
      n_mismatched++; $display("FAIL misc_result: got %h lat %0d want %h lat %0d", res, lat, {2'b00, 16'd255, 16'd255}, LAT);
    end
  endtask

  task automatic test_div_by_zero;
    int lat; logic bok; logic [33:0] res;
    do_op(32'h1234_5678, 16'd0, lat, bok, res);
    n_compared++;
    if (lat !== 1) begin n_mismatched++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    n_compared++;
    if (res !== {2'b10, 16'hFFFF, 16'h0000}) begin
      n_mismatched++; $display("FAIL dbz_result: got %h want %h", res, {2'b10, 16'hFFFF, 16'h0000});
    end
    tick();
  endtask

  task automatic test_overflow;
    int lat; logic bok; logic [33:0] res;
    do_op(32'h0001_0000, 16'd1, lat, bok, res);
    n_compared++;
    if (lat !== 1) begin n_mismatched++; $display("FAIL ovf_latency: got %0d want 1", lat); end
    n_compared++;
    if (res !== {2'b01, 16'hFFFF, 16'h0000}) begin
      n_mismatched++; $display("FAIL ovf_result: got %h want %h", res, {2'b01, 16'hFFFF, 16'h0000});
    end
    tick();
    do_op(32'h1234_5678, 16'h1234, lat, bok, res);
    n_compared++;
    if (lat !== 1 || res !== {2'b01, 16'hFFFF, 16'h0000}) begin
      n_mismatched++; $display("FAIL ovf_equal_high: got %h lat %0d want %h lat 1", res, lat, {2'b01, 16'hFFFF, 16'h0000});
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int n_done; int t1; int t2; logic [31:0] r1; logic [31:0] r2;
    n_done = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    dividend = 32'd100; divisor = 16'd3; start = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin t1 = cyc; r1 = {quotient, remainder}; end
        if (n_done == 2) begin t2 = cyc; r2 = {quotient, remainder}; end
      end
      if (cyc == 3) begin dividend = 32'd500; divisor = 16'd9; end
      if (cyc == 9) begin dividend = 32'd100; divisor = 16'd3; end
      if (cyc == 29) start = 1'b0;
    end
    n_compared++;
    if (n_done !== 2) begin n_mismatched++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
    n_compared++;
    if (t1 !== LAT) begin n_mismatched++; $display("FAIL b2b_first_done: got %0d want %0d", t1, LAT); end
    n_compared++;
    if (t2 !== 2 * LAT + 1) begin n_mismatched++; $display("FAIL b2b_second_done: got %0d want %0d", t2, 2 * LAT + 1); end
    n_compared++;
    if (r1 !== {16'd33, 16'd1}) begin n_mismatched++; $display("FAIL b2b_first_result: got %h want %h", r1, {16'd33, 16'd1}); end
    n_compared++;
    if (r2 !== {16'd33, 16'd1}) begin n_mismatched++; $display("FAIL b2b_second_result: got %h want %h", r2, {16'd33, 16'd1}); end
  endtask

  task automatic test_reset_mid_op;
    int lat; logic bok; logic [33:0] res; int stray;
    dividend = 32'd1000; divisor = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 36'd0) begin
      n_mismatched++; $display("FAIL midreset_async: got %h want 0",
                               {busy, done, quotient, remainder, div_by_zero, overflow});
    end
    #2 rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_compared++;
    if (stray !== 0) begin n_mismatched++; $display("FAIL midreset_discard: got %0d stray cycles want 0", stray); end
    do_op(32'd50, 16'd5, lat, bok, res);
    tick();
    n_compared++;
    if (lat !== LAT || res !== {2'b00, 16'd10, 16'd0}) begin
      n_mismatched++; $display("FAIL midreset_next_op: got %h lat %0d want %h lat %0d", res, lat, {2'b00, 16'd10, 16'd0}, LAT);
    end
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed;
    int lat; logic bok; logic [33:0] res;
    do_op(32'hFFFF_FC18, 16'd7, lat, bok, res);
    tick();
    n_compared++;
    if (lat !== 18) begin n_mismatched++; $display("FAIL signed_latency: got %0d want 18", lat); end
    n_compared++;
    if (res !== {2'b00, 16'hFF72, 16'hFFFA}) begin
      n_mismatched++; $display("FAIL signed_neg_dividend: got %h want %h", res, {2'b00, 16'hFF72, 16'hFFFA});
    end
    do_op(32'd1000, 16'hFFF9, lat, bok, res);
    tick();
    n_compared++;
    if (res !== {2'b00, 16'hFF72, 16'h0006}) begin
      n_mismatched++; $display("FAIL signed_neg_divisor: got %h want %h", res, {2'b00, 16'hFF72, 16'h0006});
    end
  endtask
`endif

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_basic();
`ifndef SEQ_DIVIDER_SIGNED_EN
    test_max_operands();
`else
    test_signed();
`endif
    test_misc_divide();
    test_div_by_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider_32by16.md
Name: seq_divider_32by16

Overview:
- Iterative restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor gives a WIDTH-bit quotient and a WIDTH-bit remainder.
- It is the inverse of the team's Wallace product path; the ODE solver datapath uses it for step-size and coefficient division.
- It resolves one quotient bit per clock, with a start/done handshake.
- Unsigned by default; signed operation is a compile-time option.

Parameters:
WIDTH, 16, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  2*WIDTH  captured on the accepted start.
- divisor  input  WIDTH  captured on the accepted start.
- busy  output  1  high from the cycle after start is accepted until done is asserted.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  WIDTH  result.
- remainder  output  WIDTH  result.
- div_by_zero  output  1  error flag for the last operation.
- overflow  output  1  quotient did not fit in WIDTH bits.

Behaviour:
- Reset: asynchronous active-low reset (rst_n low) gives state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
- Reset mid-operation: same as above, and the operation is discarded.
- States: IDLE, DIVIDE, FINISH.
- IDLE: on clock edge k with start=1:
  - Load the partial remainder (WIDTH+1 bits) with dividend[2W-1:W] and the quotient shift register with dividend[W-1:0].
  - Load counter=WIDTH.
  - Clear div_by_zero and overflow.
  - If divisor==0: set div_by_zero and go to FINISH.
  - Else if dividend[2W-1:W] >= divisor (unsigned): set overflow and go to FINISH.
  - Else go to DIVIDE.
- DIVIDE: each edge:
  - Shift {rem,quo} left by 1.
  - trial = shifted_rem - {0,divisor}.
  - If trial is non-negative: rem=trial and quo[0]=1; else quo[0]=0.
  - Decrement counter. When counter reaches 0 after the update, go to FINISH.
- FINISH: register the outputs, pulse done=1 for one cycle, clear busy, return to IDLE.
- Error results: on div_by_zero or overflow, quotient={WIDTH{1}} and remainder=0.
- Latency, start sampled at edge k:
  - Normal: done is high during the cycle after edge k+WIDTH+1 (17 cycles for WIDTH=16).
  - Error: done is high during the cycle after edge k+1.
- start while busy: ignored, no queuing.
- start in the FINISH cycle: ignored.
- start in the IDLE cycle immediately after done: accepted.
- Result holding: quotient, remainder and flags hold until the next accepted start's FINISH.
- dividend/divisor: may change freely after acceptance.
- Arithmetic: the partial remainder is WIDTH+1 bits, so no intermediate bit is lost. Invariant: dividend = quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- With the macro defined, operands are two's complement:
  - The IDLE accept takes magnitudes and records sign_q = sign(dividend)^sign(divisor) and sign_r = sign(dividend).
  - The overflow pre-check uses magnitudes.
  - An extra SIGN_FIX state follows DIVIDE. It negates quotient/remainder per the recorded signs (truncating division; remainder takes the sign of the dividend).
  - SIGN_FIX also sets overflow if the magnitude quotient > 2^(W-1)-1 (positive result) or > 2^(W-1) (negative result).
  - Normal latency becomes WIDTH+2.
- Without the macro: unsigned only. No SIGN_FIX state and no sign logic are synthesized.

Test Plan:
- Basic divide: dividend=1000, divisor=7, start pulse -> done exactly 17 cycles later; quotient=142, remainder=6, flags 0; busy high for the cycles in between.
- Maximum operands: dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0, overflow=0.
- Error cases:
  - dividend=0x12345678, divisor=0 -> done 1 cycle after start; div_by_zero=1, quotient=0xFFFF, remainder=0.
  - dividend=0x00010000, divisor=1 -> overflow=1, done 1 cycle after start.
- Handshake: start held high for 30 cycles with operands 100/3 -> exactly one done per accepted start. The first result is 33 r1; the second start is accepted the cycle after done. A different operand pair presented while busy does not alter the result.
- Reset mid-operation: assert rst_n=0 at cycle 8 of a 1000/7 operation -> all outputs 0 immediately (asynchronous). After release, a new 50/5 operation gives quotient=10, remainder=0.
- Signed mode (SEQ_DIVIDER_SIGNED_EN defined): -1000/7 -> quotient=-142 (0xFF72), remainder=-6 (0xFFFA), done after 18 cycles.
